// File: rtl/sdrc_bank_fsm_if.sv
// rtl/sdrc_bank_fsm_if.sv - request, command and row-status bundle between bank FSM and its neighbours
interface sdrc_bank_fsm_if #(
    parameter int APP_RW = 9
) ();
    logic              r2b_req;
    logic [11:0]       r2b_raddr;
    logic [11:0]       r2b_caddr;
    logic [APP_RW-1:0] r2b_len;
    logic              r2b_write;
    logic              b2r_ack;
    logic              b2x_req;
    logic [1:0]        b2x_cmd;
    logic [11:0]       b2x_addr;
    logic [APP_RW-1:0] b2x_len;
    logic              x2b_ack;
    logic              x2b_pre_all;
    logic              b2x_idle;
    logic              row_open;
    logic [11:0]       open_row;

    modport slave (
        input  r2b_req, r2b_raddr, r2b_caddr, r2b_len, r2b_write,
        input  x2b_ack, x2b_pre_all,
        output b2r_ack, b2x_req, b2x_cmd, b2x_addr, b2x_len,
        output b2x_idle, row_open, open_row
    );

    modport master (
        output r2b_req, r2b_raddr, r2b_caddr, r2b_len, r2b_write,
        output x2b_ack, x2b_pre_all,
        input  b2r_ack, b2x_req, b2x_cmd, b2x_addr, b2x_len,
        input  b2x_idle, row_open, open_row
    );
endinterface

// File: rtl/sdrc_bank_fsm.sv
// rtl/sdrc_bank_fsm.sv - per-bank SDRAM FSM: row hit/miss resolution, PRE/ACT sequencing and tRP/tRCD timing
module sdrc_bank_fsm #(
    parameter int APP_RW = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           cfg_trp_d,
    input  logic [3:0]           cfg_trcd_d,
    sdrc_bank_fsm_if.slave       bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TRP,
        S_ACT,
        S_TRCD,
        S_XFR
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        row_open_q, row_open_d;
    logic [11:0] open_row_q, open_row_d;
    logic [3:0]  trp_n, trcd_n, cnt_dec;
    logic        row_valid;

    always_comb begin
        trp_n      = (cfg_trp_d == 4'd0) ? 4'd1 : cfg_trp_d;
        trcd_n     = (cfg_trcd_d == 4'd0) ? 4'd1 : cfg_trcd_d;
        cnt_dec    = cnt_q - 4'd1;
        row_valid  = row_open_q & ~bus.x2b_pre_all;
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_open_d = row_open_q;
        open_row_d = open_row_q;
        case (state_q)
            S_IDLE: begin
                if (bus.x2b_pre_all) row_open_d = 1'b0;
                if (bus.r2b_req) begin
                    if (!row_valid)                        state_d = S_ACT;
                    else if (open_row_q == bus.r2b_raddr)  state_d = S_XFR;
                    else                                   state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (bus.x2b_ack) begin
                    row_open_d = 1'b0;
                    cnt_d      = trp_n;
                    // a one-cycle delay is fully covered by the ack cycle itself
                    state_d    = (trp_n == 4'd1) ? S_ACT : S_TRP;
                end
            end
            S_TRP: begin
                cnt_d = cnt_dec;
                if (cnt_dec == 4'd1) state_d = S_ACT;
            end
            S_ACT: begin
                if (bus.x2b_ack) begin
                    row_open_d = 1'b1;
                    open_row_d = bus.r2b_raddr;
                    cnt_d      = trcd_n;
                    state_d    = (trcd_n == 4'd1) ? S_XFR : S_TRCD;
                end
            end
            S_TRCD: begin
                cnt_d = cnt_dec;
                if (cnt_dec == 4'd1) state_d = S_XFR;
            end
            S_XFR: begin
                if (bus.x2b_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            row_open_q <= 1'b0;
            open_row_q <= 12'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_open_q <= row_open_d;
            open_row_q <= open_row_d;
        end
    end

    // command fields follow the held request inputs, so they stay stable under backpressure
    always_comb begin
        bus.b2x_req  = 1'b0;
        bus.b2x_cmd  = 2'b00;
        bus.b2x_addr = 12'd0;
        bus.b2x_len  = '0;
        case (state_q)
            S_PRE: bus.b2x_req = 1'b1;
            S_ACT: begin
                bus.b2x_req  = 1'b1;
                bus.b2x_cmd  = 2'b01;
                bus.b2x_addr = bus.r2b_raddr;
            end
            S_XFR: begin
                bus.b2x_req  = 1'b1;
                bus.b2x_cmd  = {1'b1, bus.r2b_write};
                bus.b2x_addr = bus.r2b_caddr;
                bus.b2x_len  = bus.r2b_len;
            end
            default: ;
        endcase
        if (reset) begin
            bus.b2x_req  = 1'b0;
            bus.b2x_cmd  = 2'b00;
            bus.b2x_addr = 12'd0;
            bus.b2x_len  = '0;
        end
    end

    assign bus.b2r_ack  = ~reset & (state_q == S_XFR) & bus.x2b_ack;
    assign bus.b2x_idle = (reset | (state_q == S_IDLE)) & ~bus.r2b_req;
    assign bus.row_open = row_open_q;
    assign bus.open_row = open_row_q;
endmodule
